sqrt_arbiter: RTL

SQRT_ARBITER -- requirements
Module: sqrt_arbiter

---
 rtl/sqrt_arb_pkg.sv | 16 +
 rtl/sqrt_arbiter_rr.sv | 31 +++
 rtl/sqrt_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/sqrt_arb_pkg.sv
// Shared types and widths for the square-root arbiter slice.
package sqrt_arb_pkg;

    localparam int XW          = 32;
    localparam int RW          = 16;
    localparam int TMO_CYC_DEF = 255;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_HI,
        S_WAIT_LO,
        S_FINISH
    } state_t;

endpackage

// File: rtl/sqrt_arbiter_rr.sv
// Combinational round-robin pick: first requester strictly after ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);

    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        // k = N revisits ptr itself last, so a lone requester at ptr still wins
        for (int k = 1; k <= N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!valid && req[j]) begin
                valid    = 1'b1;
                idx      = IW'(j);
                grant[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sqrt_arbiter.sv
// Shares one square-root core among NREQ requesters with round-robin grants.
// Optional watchdog abort is built when SQRT_ARB_WATCHDOG_EN is defined.
module sqrt_arbiter
    import sqrt_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TMO_CYC = TMO_CYC_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [XW*NREQ-1:0] xin,
    output logic [NREQ-1:0]    ack,
    output logic [NREQ-1:0]    done,
    output logic [RW-1:0]      result,
    output logic               err,
    output logic               sq_run,
    output logic [XW-1:0]      sq_xin,
    input  logic               sq_busy,
    input  logic [RW-1:0]      sq_sqrt
);

    localparam int IW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TMO_CYC < 2) begin : g_bad_param
        $error("sqrt_arbiter: NREQ or TMO_CYC out of range");
    end

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            sq_run_q, sq_run_d;
    logic [XW-1:0]   sq_xin_q, sq_xin_d;
    logic [RW-1:0]   result_q, result_d;
    logic            tmo_hit;

    logic [NREQ-1:0] arb_grant;
    logic [IW-1:0]   arb_idx;
    logic            arb_valid;

    rr_arbiter #(.N(NREQ), .IW(IW)) u_rr (
        .req   (req),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

`ifdef SQRT_ARB_WATCHDOG_EN
    localparam int WDW = $clog2(TMO_CYC + 1);
    logic [WDW-1:0] wd_q, wd_d;
    logic           err_q;
    logic           in_wait;

    assign in_wait = (state_q == S_WAIT_HI) || (state_q == S_WAIT_LO);
    assign tmo_hit = in_wait && (wd_q == WDW'(TMO_CYC - 1));

    always_comb begin
        wd_d = wd_q;
        if (state_q == S_START) begin
            wd_d = '0;
        end else if (in_wait) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= tmo_hit;
        end
    end

    assign err = err_q;
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    // ack occupies START, so the core run pulse follows in the first wait cycle
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        ack_d    = '0;
        done_d   = '0;
        sq_run_d = 1'b0;
        sq_xin_d = sq_xin_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (arb_valid) begin
                    ack_d    = arb_grant;
                    ptr_d    = arb_idx;
                    sq_xin_d = xin[XW*int'(arb_idx) +: XW];
                    state_d  = S_START;
                end
            end
            S_START: begin
                sq_run_d = 1'b1;
                state_d  = sq_busy ? S_WAIT_LO : S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (tmo_hit) begin
                    state_d = S_IDLE;
                end else if (sq_busy) begin
                    state_d = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (tmo_hit) begin
                    state_d = S_IDLE;
                end else if (!sq_busy) begin
                    result_d      = sq_sqrt;
                    done_d[ptr_q] = 1'b1;
                    state_d       = S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ptr_q    <= IW'(NREQ - 1);
            ack_q    <= '0;
            done_q   <= '0;
            sq_run_q <= 1'b0;
            sq_xin_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            ack_q    <= ack_d;
            done_q   <= done_d;
            sq_run_q <= sq_run_d;
            sq_xin_q <= sq_xin_d;
            result_q <= result_d;
        end
    end

    assign ack    = ack_q;
    assign done   = done_q;
    assign sq_run = sq_run_q;
    assign sq_xin = sq_xin_q;
    assign result = result_q;

endmodule
